pipeline_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage pipeline. It watches register addresses and control bits in ID and EX and decides when the PC and the IF/ID register hold. It also decides when IF/ID is squashed, when a bubble goes into ID/EX, and when the whole pipeline freezes for a busy data memory. The block drives the stall/flush controls of the pipeline registers and the PC register, and keeps saturating stall and flush event counters for debug.

---
 rtl/pipeline_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Produces load-use stalls, redirect squashes and memory-busy freezes,
// and keeps saturating debug counters for stall and flush events.
module pipeline_hazard_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ID_Rs1,
   input  logic [4:0]       ID_Rs2,
   input  logic             ID_UsesRs1,
   input  logic             ID_UsesRs2,
   input  logic [4:0]       EX_Rd,
   input  logic             EX_MemRead,
   input  logic             EX_Redirect,
   input  logic             MEM_Busy,
   output logic             PcStall,
   output logic             IfIdStall,
   output logic             IfIdFlush,
   output logic             IdExBubble,
   output logic             PipeFreeze,
   output logic [1:0]       State,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_FREEZE   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state_q, state_d;
   state_t ret_q, ret_d;
   state_t eff_state;
   logic   load_use;
   logic   stall_inc;
   logic   flush_inc;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // Load-use hazard: the EX load writes a register the ID instruction reads
   always_comb begin
      load_use = EX_MemRead && (EX_Rd != 5'd0) &&
                 ((ID_UsesRs1 && (ID_Rs1 == EX_Rd)) ||
                  (ID_UsesRs2 && (ID_Rs2 == EX_Rd)));
   end

   // Next-state and control outputs; leaving FREEZE acts in the saved state at once
   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      PcStall    = 1'b0;
      IfIdStall  = 1'b0;
      IfIdFlush  = 1'b0;
      IdExBubble = 1'b0;
      PipeFreeze = 1'b0;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
      eff_state  = (state_q == ST_FREEZE) ? ret_q : state_q;

      if (reset) begin
         state_d = ST_RUN;
         ret_d   = ST_RUN;
      end else if (MEM_Busy) begin
         PipeFreeze = 1'b1;
         PcStall    = 1'b1;
         IfIdStall  = 1'b1;
         stall_inc  = 1'b1;
         ret_d      = eff_state;
         state_d    = ST_FREEZE;
      end else begin
         case (eff_state)
            ST_RUN: begin
               if (EX_Redirect) begin
                  IfIdFlush  = 1'b1;
                  IdExBubble = 1'b1;
                  flush_inc  = 1'b1;
                  state_d    = ST_REDIRECT;
               end else if (load_use) begin
                  PcStall    = 1'b1;
                  IfIdStall  = 1'b1;
                  IdExBubble = 1'b1;
                  stall_inc  = 1'b1;
                  state_d    = ST_RUN;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_REDIRECT: begin
               // Squash the stale fetch word; a repeat redirect restarts the squash
               IfIdFlush = 1'b1;
               if (EX_Redirect) begin
                  IdExBubble = 1'b1;
                  flush_inc  = 1'b1;
                  state_d    = ST_REDIRECT;
               end else begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   // State and return register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         ret_q   <= ST_RUN;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
      end
   end

   // Saturating event counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign State      = state_q;
   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus a randomized run
// against a squash-pending / frozen reference model.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned CNT_W = 4;
   localparam int CMAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             reset;
   logic [4:0]       ID_Rs1, ID_Rs2, EX_Rd;
   logic             ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_Redirect, MEM_Busy;
   logic             PcStall, IfIdStall, IfIdFlush, IdExBubble, PipeFreeze;
   logic [1:0]       State;
   logic [CNT_W-1:0] StallCount, FlushCount;
   logic [4:0]       ctl;

   int total = 0;
   int bad   = 0;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .ID_Rs1(ID_Rs1), .ID_Rs2(ID_Rs2),
      .ID_UsesRs1(ID_UsesRs1), .ID_UsesRs2(ID_UsesRs2),
      .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead),
      .EX_Redirect(EX_Redirect), .MEM_Busy(MEM_Busy),
      .PcStall(PcStall), .IfIdStall(IfIdStall), .IfIdFlush(IfIdFlush),
      .IdExBubble(IdExBubble), .PipeFreeze(PipeFreeze),
      .State(State), .StallCount(StallCount), .FlushCount(FlushCount)
   );

   // {PcStall, IfIdStall, IfIdFlush, IdExBubble, PipeFreeze}
   assign ctl = {PcStall, IfIdStall, IfIdFlush, IdExBubble, PipeFreeze};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic redir, input logic busy);
      ID_Rs1 = rs1; ID_Rs2 = rs2; ID_UsesRs1 = u1; ID_UsesRs2 = u2;
      EX_Rd = rd; EX_MemRead = mr; EX_Redirect = redir; MEM_Busy = busy;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Leaves time at posedge+1 with reset released
   task automatic do_reset();
      reset = 1'b1;
      idle();
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
      #3;
      total++;
      if (ctl !== 5'b00000) begin bad++; $display("FAIL reset_ctl: got %b want 00000", ctl); end
      total++;
      if (State !== 2'd0 || StallCount !== '0 || FlushCount !== '0) begin
         bad++; $display("FAIL reset_regs: state=%0d stall=%0d flush=%0d want 0 0 0", State, StallCount, FlushCount);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      idle();
      #3;
      total++;
      if (ctl !== 5'b00000 || State !== 2'd0) begin
         bad++; $display("FAIL idle_after_reset: ctl=%b state=%0d want 00000 0", ctl, State);
      end
      next_cycle();
   endtask

   task automatic test_load_use();
      do_reset();
      drive(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
      #3;
      total++;
      if (ctl !== 5'b11010) begin bad++; $display("FAIL lu_ctl: got %b want 11010", ctl); end
      next_cycle();
      idle();
      #3;
      total++;
      if (StallCount !== 4'd1 || ctl !== 5'b00000 || State !== 2'd0) begin
         bad++; $display("FAIL lu_after: stall=%0d ctl=%b state=%0d want 1 00000 0", StallCount, ctl, State);
      end
      next_cycle();
      drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
      #3;
      total++;
      if (ctl !== 5'b00000) begin bad++; $display("FAIL lu_rd0_ctl: got %b want 00000", ctl); end
      next_cycle();
      idle();
      #3;
      total++;
      if (StallCount !== 4'd1) begin bad++; $display("FAIL lu_rd0_cnt: got %0d want 1", StallCount); end
      next_cycle();
   endtask

   task automatic test_redirect();
      do_reset();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      #3;
      total++;
      if (ctl !== 5'b00110 || State !== 2'd0) begin
         bad++; $display("FAIL redir_c0: ctl=%b state=%0d want 00110 0", ctl, State);
      end
      next_cycle();
      idle();
      #3;
      total++;
      if (ctl !== 5'b00100 || State !== 2'd1) begin
         bad++; $display("FAIL redir_c1: ctl=%b state=%0d want 00100 1", ctl, State);
      end
      next_cycle();
      #3;
      total++;
      if (ctl !== 5'b00000 || State !== 2'd0 || FlushCount !== 4'd1) begin
         bad++; $display("FAIL redir_c2: ctl=%b state=%0d flush=%0d want 00000 0 1", ctl, State, FlushCount);
      end
      next_cycle();
   endtask

   task automatic test_freeze_in_redirect();
      do_reset();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
         #3;
         total++;
         if (ctl !== 5'b11001 || State !== ((i == 0) ? 2'd1 : 2'd2)) begin
            bad++; $display("FAIL frz_cyc%0d: ctl=%b state=%0d want 11001 %0d", i, ctl, State, (i == 0) ? 1 : 2);
         end
         next_cycle();
      end
      idle();
      #3;
      total++;
      if (ctl !== 5'b00100 || State !== 2'd2) begin
         bad++; $display("FAIL frz_exit: ctl=%b state=%0d want 00100 2", ctl, State);
      end
      next_cycle();
      #3;
      total++;
      if (ctl !== 5'b00000 || State !== 2'd0 || StallCount !== 4'd3 || FlushCount !== 4'd1) begin
         bad++; $display("FAIL frz_done: ctl=%b state=%0d stall=%0d flush=%0d want 00000 0 3 1",
                         ctl, State, StallCount, FlushCount);
      end
      next_cycle();
   endtask

   task automatic test_lu_and_redirect();
      do_reset();
      drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
      #3;
      total++;
      if (ctl !== 5'b00110) begin bad++; $display("FAIL lu_redir_ctl: got %b want 00110", ctl); end
      next_cycle();
      idle();
      #3;
      total++;
      if (StallCount !== 4'd0 || FlushCount !== 4'd1 || State !== 2'd1) begin
         bad++; $display("FAIL lu_redir_cnt: stall=%0d flush=%0d state=%0d want 0 1 1", StallCount, FlushCount, State);
      end
      next_cycle();
   endtask

   task automatic test_saturation();
      do_reset();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) next_cycle();
      #1;
      total++;
      if (StallCount !== 4'd15 || ctl !== 5'b11001) begin
         bad++; $display("FAIL sat: stall=%0d ctl=%b want 15 11001", StallCount, ctl);
      end
      #1 reset = 1'b1;
      #1;
      total++;
      if (ctl !== 5'b00000 || State !== 2'd0 || StallCount !== '0 || FlushCount !== '0) begin
         bad++; $display("FAIL async_reset: ctl=%b state=%0d stall=%0d flush=%0d want 00000 0 0 0",
                         ctl, State, StallCount, FlushCount);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      idle();
   endtask

   // Model: squash_pending = a fetch word still needs squashing; frozen = last cycle was busy
   task automatic test_random();
      bit squash_pending = 1'b0;
      bit frozen = 1'b0;
      int m_stall = 0;
      int m_flush = 0;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         logic [4:0] rs1, rs2, rd;
         logic u1, u2, mr, redir, busy, rst, lu;
         logic [4:0] exp_ctl;
         int exp_state;
         rs1 = 5'($urandom_range(0, 3));
         rs2 = 5'($urandom_range(0, 3));
         rd  = 5'($urandom_range(0, 3));
         u1 = 1'($urandom_range(0, 1));
         u2 = 1'($urandom_range(0, 1));
         mr = 1'($urandom_range(0, 1));
         redir = ($urandom_range(0, 99) < 15);
         busy  = ($urandom_range(0, 99) < 20);
         rst   = ($urandom_range(0, 99) < 4);
         reset = rst;
         drive(rs1, rs2, u1, u2, rd, mr, redir, busy);
         lu = mr && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
         exp_state = frozen ? 2 : int'(squash_pending);
         if (rst) begin
            exp_ctl = 5'b00000;
            exp_state = 0;
            m_stall = 0;
            m_flush = 0;
         end else if (busy) begin
            exp_ctl = 5'b11001;
         end else begin
            exp_ctl = {(!squash_pending && !redir && lu), (!squash_pending && !redir && lu),
                       (squash_pending || redir), (redir || (!squash_pending && lu)), 1'b0};
         end
         #3;
         total++;
         if (ctl !== exp_ctl || State !== 2'(exp_state) ||
             StallCount !== CNT_W'(m_stall) || FlushCount !== CNT_W'(m_flush)) begin
            bad++;
            $display("FAIL rand_cyc%0d: ctl=%b st=%0d stall=%0d flush=%0d want %b %0d %0d %0d",
                     n, ctl, State, StallCount, FlushCount, exp_ctl, exp_state, m_stall, m_flush);
         end
         if (rst) begin
            squash_pending = 1'b0;
            frozen = 1'b0;
         end else if (busy) begin
            frozen = 1'b1;
            if (m_stall < CMAX) m_stall++;
         end else begin
            frozen = 1'b0;
            if (!squash_pending && !redir && lu && m_stall < CMAX) m_stall++;
            if (redir && m_flush < CMAX) m_flush++;
            squash_pending = redir;
         end
         next_cycle();
         // Periodic reset keeps the 4-bit counters mostly away from saturation
         if (n % 40 == 39) begin
            do_reset();
            squash_pending = 1'b0;
            frozen = 1'b0;
            m_stall = 0;
            m_flush = 0;
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      #1;
      test_reset();
      test_load_use();
      test_redirect();
      test_freeze_in_redirect();
      test_lu_and_redirect();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
